// File: rtl/mnist_pkg.sv
// Shared definitions for the MNIST pixel feeder: frame geometry, digit width
// and the feeder state encoding.
package mnist_pkg;

    localparam int PIXELS_PER_BYTE = 4;
    localparam int FRAME_BYTES     = 16;
    localparam int BYTE_W          = 8;
    localparam int DIGIT_W         = 4;
    localparam int ADDR_W          = $clog2(FRAME_BYTES);
    localparam int WCNT_W          = ADDR_W + 1;

    typedef enum logic [1:0] {
        ST_FILL,
        ST_LAUNCH,
        ST_STREAM,
        ST_WAIT_DONE
    } feeder_state_t;

endpackage

// File: rtl/mnist_pixel_feeder_frame_buffer.sv
// 16 x 8 register file holding one packed frame: single write port,
// combinational read port. Contents are not reset.
module frame_buffer
    import mnist_pkg::*;
#(
    parameter int DATA_W = BYTE_W,
    parameter int DEPTH  = FRAME_BYTES,
    parameter int AW     = ADDR_W
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/mnist_pixel_feeder.sv
// Stages one packed 8x8 frame from the host, launches the core, replays the
// 16 bytes on consecutive cycles, and holds the core's prediction for the host.
module mnist_pixel_feeder
    import mnist_pkg::*;
#(
    parameter int TIMEOUT = 8191
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [BYTE_W-1:0]  in_data,
    input  logic               in_valid,
    input  logic               in_sof,
    output logic               in_ready,
    output logic               core_start,
    output logic [BYTE_W-1:0]  core_pixels,
    input  logic               core_busy,
    input  logic               core_done,
    input  logic [DIGIT_W-1:0] core_prediction,
    output logic               result_valid,
    output logic [DIGIT_W-1:0] result_digit,
    output logic               result_err
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [WCNT_W-1:0] W_LAST = WCNT_W'(FRAME_BYTES - 1);
    localparam logic [ADDR_W-1:0] R_LAST = ADDR_W'(FRAME_BYTES - 1);

    feeder_state_t state, state_next;
    logic [WCNT_W-1:0]  wcnt, wcnt_next;
    logic [ADDR_W-1:0]  rcnt, rcnt_next;
    logic [TW-1:0]      tcnt, tcnt_next;
    logic               valid_next, err_next;
    logic [DIGIT_W-1:0] digit_next;

    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic [BYTE_W-1:0]  rd_data;

    frame_buffer #(
        .DATA_W (BYTE_W),
        .DEPTH  (FRAME_BYTES),
        .AW     (ADDR_W)
    ) u_buf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (in_data),
        .rd_addr (rcnt),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_FILL;
            wcnt         <= '0;
            rcnt         <= '0;
            tcnt         <= '0;
            result_valid <= 1'b0;
            result_err   <= 1'b0;
            result_digit <= '0;
        end else begin
            state        <= state_next;
            wcnt         <= wcnt_next;
            rcnt         <= rcnt_next;
            tcnt         <= tcnt_next;
            result_valid <= valid_next;
            result_err   <= err_next;
            result_digit <= digit_next;
        end
    end

    always_comb begin
        state_next  = state;
        wcnt_next   = wcnt;
        rcnt_next   = rcnt;
        tcnt_next   = tcnt;
        valid_next  = result_valid;
        err_next    = result_err;
        digit_next  = result_digit;
        in_ready    = 1'b0;
        core_start  = 1'b0;
        core_pixels = '0;
        wr_en       = 1'b0;
        wr_addr     = '0;

        unique case (state)
            ST_FILL: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    // A start-of-frame byte always restarts the frame, even
                    // when it lands where the 16th byte would have gone.
                    if (in_sof) begin
                        wr_en      = 1'b1;
                        wr_addr    = '0;
                        wcnt_next  = WCNT_W'(1);
                        valid_next = 1'b0;
                        err_next   = 1'b0;
                    end else if (wcnt != '0) begin
                        wr_en     = 1'b1;
                        wr_addr   = wcnt[ADDR_W-1:0];
                        wcnt_next = wcnt + 1'b1;
                        if (wcnt == W_LAST) begin
                            state_next = ST_LAUNCH;
                        end
                    end
                end
            end

            ST_LAUNCH: begin
                if (!(core_busy && !core_done)) begin
                    core_start = 1'b1;
                    rcnt_next  = '0;
                    state_next = ST_STREAM;
                end
            end

            ST_STREAM: begin
                core_pixels = rd_data;
                rcnt_next   = rcnt + 1'b1;
                if (rcnt == R_LAST) begin
                    tcnt_next  = '0;
                    state_next = ST_WAIT_DONE;
                end
            end

            ST_WAIT_DONE: begin
                // A done in the same cycle as the last timeout tick still counts.
                if (core_done) begin
                    digit_next = core_prediction;
                    valid_next = 1'b1;
                    wcnt_next  = '0;
                    state_next = ST_FILL;
                end else if (tcnt == T_LAST) begin
                    err_next   = 1'b1;
                    valid_next = 1'b0;
                    wcnt_next  = '0;
                    state_next = ST_FILL;
                end else begin
                    tcnt_next = tcnt + 1'b1;
                end
            end

            default: begin
                state_next = ST_FILL;
            end
        endcase
    end

endmodule

// File: doc/mnist_pixel_feeder.md
# mnist_pixel_feeder

Upstream staging block for the MNIST inference core (`mnist_top`). It accepts one 8×8 image from the host as 16 packed bytes (4 × 2-bit pixels each, px0 in [1:0]) through a valid/ready byte interface. The bytes arrive at arbitrary rate, so the block buffers them. It then launches the core and replays the 16 bytes on 16 consecutive cycles, matching the core's load window. It also captures the core's prediction and holds it for the host.

## Interface
Parameters:
- `TIMEOUT`, default 8191: maximum cycles to wait for `core_done` after the last streamed byte.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge
- `rst`  in  1  reset, synchronous and active-high
- `in_data`  in  8  packed pixel byte from the host
- `in_valid`  in  1  `in_data` is valid
- `in_sof`  in  1  qualifies `in_data` as byte 0 of a frame
- `in_ready`  out  1  the block accepts a byte this cycle
- `core_start`  out  1  start pulse to the core
- `core_pixels`  out  8  byte presented to the core's `pixels_in`
- `core_busy`  in  1  core busy flag
- `core_done`  in  1  core done flag
- `core_prediction`  in  4  core result
- `result_valid`  out  1  `result_digit` holds a fresh prediction
- `result_digit`  out  4  latched prediction, 0–9
- `result_err`  out  1  the last launch timed out

## Operation
- A byte is accepted when `in_valid && in_ready` at a clock edge.
- **Buffer:** 16 × 8-bit register file `buf`, with a 5-bit write count `wcnt`.
- **States:** FILL, LAUNCH, STREAM, WAIT_DONE.
- **FILL:**
  - `in_ready`=1.
  - An accepted byte with `in_sof`=1 writes `buf[0]` and sets `wcnt`=1, at any count. This resyncs a partial frame.
  - An accepted byte without `in_sof` writes `buf[wcnt]` and increments `wcnt`.
  - An accepted byte without `in_sof` when `wcnt`=0 is dropped.
  - When `wcnt` reaches 16, go to LAUNCH.
  - The first accepted byte of a frame clears `result_valid` and `result_err`.
- **LAUNCH:**
  - `in_ready`=0.
  - If `core_busy`=1 and `core_done`=0, wait here.
  - Otherwise drive `core_start`=1 for exactly one cycle, then go to STREAM with `rcnt`=0.
- **STREAM:**
  - `core_pixels`=`buf[rcnt]`; `rcnt` increments every cycle.
  - After `rcnt`=15 is presented, go to WAIT_DONE and clear the timeout counter.
- **WAIT_DONE:**
  - On `core_done`=1, latch `result_digit`←`core_prediction`, set `result_valid`=1, and go to FILL with `wcnt`=0.
  - If the counter reaches `TIMEOUT`, set `result_err`=1, leave `result_valid`=0, and go to FILL.
  - `core_start` is held 0 here. This lets the core leave its DONE state on the next cycle.
- `core_pixels` is 0 outside STREAM.
- A `core_done` seen outside WAIT_DONE is ignored.

## Timing
- **Reset:**
  - state=FILL, `wcnt`=`rcnt`=0.
  - `in_ready`=1, since it is decoded from state.
  - `core_start`=0, `core_pixels`=0.
  - `result_valid`=0, `result_digit`=0, `result_err`=0.
  - Buffer contents are don't-care.
  - A mid-frame reset discards the partial frame and any in-flight launch. The core's own reset must be asserted alongside `rst` at the top level.
- **Launch alignment:** with `core_start`=1 in cycle T, `core_pixels`=`buf[k]` in cycle T+1+k for k=0..15. There are no gaps.
- **Minimum latency:**
  - last accepted byte → `core_start`: 1 cycle.
  - last streamed byte → WAIT_DONE: 1 cycle.
  - `core_done` high → `result_valid` high: 1 cycle.
- `in_ready` drops the cycle after the 16th byte is accepted. Bytes are never accepted outside FILL.
- If `in_sof` and a 16th-byte condition coincide, `in_sof` wins: `wcnt`=1 and no launch.
- `result_valid` and `result_digit` stay stable until the next frame's first accepted byte.

## Structure
- Shared package `mnist_pkg`:
  - feeder state encoding;
  - `PIXELS_PER_BYTE`=4, `FRAME_BYTES`=16;
  - digit width of 4.
- One sub-module is natural: `frame_buffer`, the 16×8 register file with write port (addr, data, en) and combinational read port. The FSM and counters stay in the top.
- Timeout counter width is $clog2(`TIMEOUT`+1).

## Test plan
- **Nominal frame:**
  - Stimulus: 16 bytes 0x00..0x0F with `in_sof` on byte 0 and random `in_valid` gaps.
  - Required: `core_start` one cycle, then `core_pixels` 0x00..0x0F on 16 consecutive cycles.
  - Stimulus: core model answers `core_done` with prediction 7.
  - Required: `result_valid`=1, `result_digit`=7.
- **Resync:** send 9 bytes, then a new `in_sof` frame of 16 bytes 0xA0..0xAF. Required: streamed bytes are 0xA0..0xAF only.
- **Core busy:** hold `core_busy`=1 for 20 cycles after the 16th byte. Required: `core_start` is delayed until `core_busy` falls, and alignment is preserved.
- **Timeout:** `TIMEOUT`=50 and the core never asserts done. Required: `result_err`=1 at cycle 50 of WAIT_DONE, `result_valid`=0, `in_ready`=1 next cycle.
- **Reset mid-STREAM:** assert `rst` at `rcnt`=5. Required: all outputs at reset values next cycle, no further `core_pixels` activity, and the next frame processes normally.
- **Back-to-back frames with the real `mnist_top`:** two different digit images. Required: two `result_valid` events with the correct digits, and `result_valid` cleared by the second frame's first byte.
